// File: rtl/ibex_pkg.sv
// Shared types for the data-bus arbiter that merges the core LSU and the
// register-file cache spill/fill engine onto one external data port.
//   arb_src_e   : identifies which requester issued (and owns) a bus access
//   arb_state_e : owner FSM states of the arbiter
//   RfBe        : byte enable driven for spill/fill accesses (always full word)
package ibex_pkg;

  typedef enum logic {
    ArbSrcCore = 1'b0,
    ArbSrcRf   = 1'b1
  } arb_src_e;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbHold = 2'd1,
    ArbLock = 2'd2
  } arb_state_e;

  localparam logic [3:0] RfBe = 4'hF;

endpackage

// File: rtl/ibex_arb_id_fifo.sv
// In-order queue of source IDs for granted-but-unanswered bus transactions.
// The head entry tells the arbiter which requester the next response belongs to.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (the only flush)
//   push_i/data_i : enqueue one source ID (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   data_o        : current head, valid while empty_o=0
//   full_o        : Depth entries held
//   empty_o       : no entries held
module ibex_arb_id_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  arb_src_e data_i,
  input  logic     pop_i,
  output arb_src_e data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0] count_reg, count_next;
  logic [Depth-1:0] entry_we;
  arb_src_e         mem_reg [Depth];
  logic             push_en, pop_en;

  assign full_o  = (count_reg == CntW'(Depth));
  assign empty_o = (count_reg == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = mem_reg[rd_ptr_reg];

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry_we
      assign entry_we[gi] = push_en & (wr_ptr_reg == PtrW'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_next = push_en ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop_en ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next  = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < Depth; i++) mem_reg[i] <= ArbSrcCore;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      for (int i = 0; i < Depth; i++) begin
        if (entry_we[i]) mem_reg[i] <= data_i;
      end
    end
  end

endmodule

// File: rtl/ibex_data_bus_arb.sv
// Shares the external data port between the core LSU and the register-file
// cache spill/fill engine. Arbitration is combinational (zero added latency),
// a stalled request keeps its owner until granted, an rf burst can lock the
// port, and an in-order ID queue routes each response back to its issuer.
// Ports:
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   core_req_i/we/be/addr/wdata         : core LSU request and payload
//   core_gnt_o, core_rvalid_o/rdata/err : core grant and response
//   rf_req_i/we/addr/wdata, rf_lock_i   : spill/fill request, payload, burst lock
//   rf_gnt_o, rf_rvalid_o/rdata/err     : spill/fill grant and response
//   data_req_o/we/be/addr/wdata         : external bus request and payload
//   data_gnt_i, data_rvalid_i/rdata/err : external bus grant and response
//   busy_o                              : responses outstanding or port locked
module ibex_data_bus_arb
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RfPriority     = 1'b1,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  input  logic        rf_req_i,
  input  logic        rf_we_i,
  input  logic [31:0] rf_addr_i,
  input  logic [31:0] rf_wdata_i,
  input  logic        rf_lock_i,
  output logic        rf_gnt_o,
  output logic        rf_rvalid_o,
  output logic [31:0] rf_rdata_o,
  output logic        rf_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        busy_o
);

  localparam int unsigned StarveW = $clog2(StarveLimit + 1);
  localparam arb_src_e    HiSrc   = RfPriority ? ArbSrcRf : ArbSrcCore;
  localparam arb_src_e    LoSrc   = RfPriority ? ArbSrcCore : ArbSrcRf;

  arb_state_e         state_reg, state_next;
  arb_src_e           owner_reg, owner_next;
  logic [StarveW-1:0] starve_cnt_reg, starve_cnt_next;

  arb_src_e win_src, sel_src, head_src;
  logic     sel_req, bus_hs, lock_on_gnt;
  logic     fifo_full, fifo_empty, resp_pop;
  logic     starved, lo_req, hi_gnt, lo_gnt;

  // ---------------- idle arbitration ----------------
  assign starved = (starve_cnt_reg == StarveW'(StarveLimit));

  always_comb begin
    win_src = HiSrc;
    if (core_req_i && !rf_req_i) begin
      win_src = ArbSrcCore;
    end else if (rf_req_i && !core_req_i) begin
      win_src = ArbSrcRf;
    end else if (starved) begin
      // The low-priority side has lost StarveLimit times in a row: let it in once.
      win_src = LoSrc;
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ArbIdle;
      owner_reg      <= ArbSrcCore;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    sel_src = owner_reg;
    sel_req = 1'b0;
    case (state_reg)
      ArbIdle: begin
        sel_src = win_src;
        sel_req = core_req_i | rf_req_i;
      end
      ArbHold: begin
        sel_src = owner_reg;
        sel_req = (owner_reg == ArbSrcRf) ? rf_req_i : core_req_i;
      end
      ArbLock: begin
        // Core is masked for the whole burst, including the cycle lock falls.
        sel_src = ArbSrcRf;
        sel_req = rf_req_i;
      end
      default: begin
        sel_src = owner_reg;
        sel_req = 1'b0;
      end
    endcase
  end

  // rst_ni gating keeps every output quiet while reset is held, even if
  // requesters are still driving their request lines.
  assign data_req_o  = sel_req & ~fifo_full & rst_ni;
  assign bus_hs      = data_req_o & data_gnt_i;
  assign core_gnt_o  = bus_hs & (sel_src == ArbSrcCore);
  assign rf_gnt_o    = bus_hs & (sel_src == ArbSrcRf);
  assign lock_on_gnt = rf_gnt_o & rf_lock_i;

  always_comb begin
    data_we_o    = 1'b0;
    data_be_o    = 4'h0;
    data_addr_o  = 32'h0;
    data_wdata_o = 32'h0;
    if (data_req_o) begin
      if (sel_src == ArbSrcRf) begin
        data_we_o    = rf_we_i;
        data_be_o    = RfBe;
        data_addr_o  = rf_addr_i;
        data_wdata_o = rf_wdata_i;
      end else begin
        data_we_o    = core_we_i;
        data_be_o    = core_be_i;
        data_addr_o  = core_addr_i;
        data_wdata_o = core_wdata_i;
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    case (state_reg)
      ArbIdle: begin
        if (bus_hs) begin
          state_next = lock_on_gnt ? ArbLock : ArbIdle;
          owner_next = sel_src;
        end else if (data_req_o) begin
          state_next = ArbHold;
          owner_next = sel_src;
        end
      end
      ArbHold: begin
        if (bus_hs) begin
          state_next = lock_on_gnt ? ArbLock : ArbIdle;
        end else if (!sel_req) begin
          // Illegal request withdrawal; recover rather than wedge the port.
          state_next = ArbIdle;
        end
      end
      ArbLock: begin
        owner_next = ArbSrcRf;
        if (bus_hs) begin
          state_next = rf_lock_i ? ArbLock : ArbIdle;
        end else if (!rf_lock_i) begin
          state_next = data_req_o ? ArbHold : ArbIdle;
        end
      end
      default: begin
        state_next = ArbIdle;
      end
    endcase
  end

  // ---------------- starvation counter ----------------
  assign lo_req = (LoSrc == ArbSrcCore) ? core_req_i : rf_req_i;
  assign lo_gnt = (LoSrc == ArbSrcCore) ? core_gnt_o : rf_gnt_o;
  assign hi_gnt = (LoSrc == ArbSrcCore) ? rf_gnt_o : core_gnt_o;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (lo_gnt) begin
      starve_cnt_next = '0;
    end else if (lo_req && hi_gnt && !starved) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // ---------------- ID queue and response routing ----------------
  assign resp_pop = data_rvalid_i & ~fifo_empty;

  ibex_arb_id_fifo #(
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (bus_hs),
    .data_i (sel_src),
    .pop_i  (resp_pop),
    .data_o (head_src),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign core_rvalid_o = resp_pop & (head_src == ArbSrcCore);
  assign rf_rvalid_o   = resp_pop & (head_src == ArbSrcRf);
  assign core_rdata_o  = core_rvalid_o ? data_rdata_i : 32'h0;
  assign rf_rdata_o    = rf_rvalid_o ? data_rdata_i : 32'h0;
  assign core_err_o    = core_rvalid_o & data_err_i;
  assign rf_err_o      = rf_rvalid_o & data_err_i;

  assign busy_o = ~fifo_empty | (state_reg == ArbLock);

  // ---------------- protocol checks ----------------
  rvalid_needs_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> !fifo_empty);

  hold_keeps_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == ArbHold) |-> sel_req);

endmodule

// File: tb/tb_ibex_data_bus_arb.sv
module tb_ibex_data_bus_arb;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic        rf_req_i, rf_we_i, rf_lock_i;
  logic [31:0] rf_addr_i, rf_wdata_i;
  logic        rf_gnt_o, rf_rvalid_o, rf_err_o;
  logic [31:0] rf_rdata_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic        busy_o;

  int errors;
  int checks;

  ibex_data_bus_arb #(
    .MaxOutstanding(2),
    .RfPriority    (1'b1),
    .StarveLimit   (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_be_i    (core_be_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_gnt_o   (core_gnt_o),
    .core_rvalid_o(core_rvalid_o),
    .core_rdata_o (core_rdata_o),
    .core_err_o   (core_err_o),
    .rf_req_i     (rf_req_i),
    .rf_we_i      (rf_we_i),
    .rf_addr_i    (rf_addr_i),
    .rf_wdata_i   (rf_wdata_i),
    .rf_lock_i    (rf_lock_i),
    .rf_gnt_o     (rf_gnt_o),
    .rf_rvalid_o  (rf_rvalid_o),
    .rf_rdata_o   (rf_rdata_o),
    .rf_err_o     (rf_err_o),
    .data_req_o   (data_req_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_addr_o  (data_addr_o),
    .data_wdata_o (data_wdata_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i),
    .data_err_i   (data_err_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 time unit later, well away from either edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    core_req_i    = 1'b0;
    core_we_i     = 1'b0;
    core_be_i     = 4'h0;
    core_addr_i   = 32'h0;
    core_wdata_i  = 32'h0;
    rf_req_i      = 1'b0;
    rf_we_i       = 1'b0;
    rf_addr_i     = 32'h0;
    rf_wdata_i    = 32'h0;
    rf_lock_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'h0;
    data_err_i    = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_ni = 1'b0;
    clear_inputs();
    #2;
    chk1("rst_data_req", data_req_o, 1'b0);
    chk1("rst_core_gnt", core_gnt_o, 1'b0);
    chk1("rst_rf_gnt", rf_gnt_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk32("rst_addr", data_addr_o, 32'h0);
    cyc();
    cyc();
    rst_ni = 1'b1;

    // Core-only read of 0x100
    cyc();
    core_req_i = 1'b1; core_addr_i = 32'h100; core_be_i = 4'hF; data_gnt_i = 1'b1;
    #1;
    chk1("t1_req", data_req_o, 1'b1);
    chk32("t1_addr", data_addr_o, 32'h100);
    chk32("t1_be", {28'h0, data_be_o}, 32'hF);
    chk1("t1_core_gnt", core_gnt_o, 1'b1);
    chk1("t1_rf_gnt", rf_gnt_o, 1'b0);
    cyc();
    clear_inputs(); data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
    #1;
    chk1("t1_busy", busy_o, 1'b1);
    chk1("t1_core_rvalid", core_rvalid_o, 1'b1);
    chk32("t1_core_rdata", core_rdata_o, 32'hDEADBEEF);
    chk1("t1_rf_rvalid", rf_rvalid_o, 1'b0);
    chk32("t1_rf_rdata", rf_rdata_o, 32'h0);
    cyc();
    clear_inputs();
    #1;
    chk1("t1_idle_busy", busy_o, 1'b0);

    // Simultaneous requests: rf first, then core; responses in issue order
    cyc();
    core_req_i = 1'b1; core_addr_i = 32'h200; core_be_i = 4'h3;
    rf_req_i = 1'b1; rf_addr_i = 32'h300; rf_we_i = 1'b1; rf_wdata_i = 32'h55;
    data_gnt_i = 1'b1;
    #1;
    chk1("t2_rf_gnt", rf_gnt_o, 1'b1);
    chk1("t2_core_gnt0", core_gnt_o, 1'b0);
    chk32("t2_rf_addr", data_addr_o, 32'h300);
    chk1("t2_we", data_we_o, 1'b1);
    chk32("t2_wdata", data_wdata_o, 32'h55);
    chk32("t2_rf_be", {28'h0, data_be_o}, 32'hF);
    cyc();
    rf_req_i = 1'b0; rf_we_i = 1'b0;
    #1;
    chk1("t2_core_gnt", core_gnt_o, 1'b1);
    chk32("t2_core_addr", data_addr_o, 32'h200);
    chk32("t2_core_be", {28'h0, data_be_o}, 32'h3);
    cyc();
    clear_inputs(); data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
    #1;
    chk1("t2_rsp1_rf", rf_rvalid_o, 1'b1);
    chk32("t2_rsp1_rdata", rf_rdata_o, 32'h11111111);
    chk1("t2_rsp1_rf_err", rf_err_o, 1'b0);
    chk1("t2_rsp1_core", core_rvalid_o, 1'b0);
    cyc();
    data_rdata_i = 32'h22222222; data_err_i = 1'b1;
    #1;
    chk1("t2_rsp2_core", core_rvalid_o, 1'b1);
    chk32("t2_rsp2_rdata", core_rdata_o, 32'h22222222);
    chk1("t2_rsp2_err", core_err_o, 1'b1);
    chk1("t2_rsp2_rf", rf_rvalid_o, 1'b0);
    cyc();
    clear_inputs();
    #1;
    chk1("t2_busy", busy_o, 1'b0);

    // rf locked burst of 4 beats masks the core
    cyc();
    rf_req_i = 1'b1; rf_lock_i = 1'b1; rf_addr_i = 32'h400;
    core_req_i = 1'b1; core_addr_i = 32'h480; core_be_i = 4'hF; data_gnt_i = 1'b1;
    #1;
    chk1("t3_b1_rf_gnt", rf_gnt_o, 1'b1);
    chk1("t3_b1_core_gnt", core_gnt_o, 1'b0);
    for (int b = 2; b <= 4; b++) begin
      cyc();
      data_rvalid_i = 1'b1; rf_addr_i = 32'h400 + 32'(4 * (b - 1));
      #1;
      chk1("t3_beat_core_gnt", core_gnt_o, 1'b0);
      chk1("t3_beat_rf_gnt", rf_gnt_o, 1'b1);
      chk1("t3_beat_rf_rvalid", rf_rvalid_o, 1'b1);
      chk1("t3_beat_busy", busy_o, 1'b1);
    end
    cyc();
    rf_req_i = 1'b0; rf_lock_i = 1'b0;
    #1;
    chk1("t3_release_core_gnt", core_gnt_o, 1'b0);
    chk1("t3_release_req", data_req_o, 1'b0);
    chk1("t3_release_rvalid", rf_rvalid_o, 1'b1);
    chk1("t3_release_busy", busy_o, 1'b1);
    cyc();
    data_rvalid_i = 1'b0;
    #1;
    chk1("t3_core_gnt", core_gnt_o, 1'b1);
    chk32("t3_core_addr", data_addr_o, 32'h480);
    cyc();
    clear_inputs(); data_rvalid_i = 1'b1; data_rdata_i = 32'h33;
    #1;
    chk1("t3_core_rvalid", core_rvalid_o, 1'b1);
    cyc();
    clear_inputs();
    #1;
    chk1("t3_busy", busy_o, 1'b0);

    // Stalled bus: core owns the port, rf arrives during the stall
    cyc();
    core_req_i = 1'b1; core_addr_i = 32'h500; core_be_i = 4'hF;
    #1;
    chk1("t4_req", data_req_o, 1'b1);
    chk32("t4_addr_c0", data_addr_o, 32'h500);
    chk1("t4_core_gnt_c0", core_gnt_o, 1'b0);
    cyc();
    #1;
    chk32("t4_addr_c1", data_addr_o, 32'h500);
    cyc();
    rf_req_i = 1'b1; rf_addr_i = 32'h600;
    #1;
    chk32("t4_addr_c2", data_addr_o, 32'h500);
    chk1("t4_rf_gnt_c2", rf_gnt_o, 1'b0);
    cyc();
    data_gnt_i = 1'b1;
    #1;
    chk1("t4_core_gnt", core_gnt_o, 1'b1);
    chk1("t4_rf_gnt", rf_gnt_o, 1'b0);
    chk32("t4_addr_gnt", data_addr_o, 32'h500);
    cyc();
    core_req_i = 1'b0;
    #1;
    chk1("t4_rf_gnt_after", rf_gnt_o, 1'b1);
    chk32("t4_rf_addr", data_addr_o, 32'h600);

    // Queue full at MaxOutstanding=2
    cyc();
    rf_req_i = 1'b0; core_req_i = 1'b1; core_addr_i = 32'h700;
    #1;
    chk1("t5_full_req", data_req_o, 1'b0);
    chk1("t5_full_gnt", core_gnt_o, 1'b0);
    cyc();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h44;
    #1;
    chk1("t5_pop_req", data_req_o, 1'b0);
    chk1("t5_pop_core_rvalid", core_rvalid_o, 1'b1);
    cyc();
    data_rvalid_i = 1'b0;
    #1;
    chk1("t5_issue_gnt", core_gnt_o, 1'b1);
    chk32("t5_issue_addr", data_addr_o, 32'h700);
    cyc();
    clear_inputs(); data_rvalid_i = 1'b1; data_rdata_i = 32'h55;
    #1;
    chk1("t5_rsp_rf", rf_rvalid_o, 1'b1);
    chk32("t5_rsp_rf_rdata", rf_rdata_o, 32'h55);
    chk1("t5_rsp_rf_core", core_rvalid_o, 1'b0);
    cyc();
    data_rdata_i = 32'h66;
    #1;
    chk1("t5_rsp_core", core_rvalid_o, 1'b1);
    chk32("t5_rsp_core_rdata", core_rdata_o, 32'h66);
    cyc();
    clear_inputs();
    #1;
    chk1("t5_busy", busy_o, 1'b0);

    // Starvation: core wins on its 5th contended request cycle
    cyc();
    core_req_i = 1'b1; core_addr_i = 32'h800; core_be_i = 4'hF;
    rf_req_i = 1'b1; rf_addr_i = 32'h900; data_gnt_i = 1'b1;
    #1;
    chk1("t6_c1_rf_gnt", rf_gnt_o, 1'b1);
    chk1("t6_c1_core_gnt", core_gnt_o, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      data_rvalid_i = 1'b1;
      #1;
      chk1("t6_rf_gnt", rf_gnt_o, 1'b1);
      chk1("t6_core_gnt", core_gnt_o, 1'b0);
    end
    cyc();
    #1;
    chk1("t6_c5_core_gnt", core_gnt_o, 1'b1);
    chk1("t6_c5_rf_gnt", rf_gnt_o, 1'b0);
    chk32("t6_c5_addr", data_addr_o, 32'h800);
    cyc();
    #1;
    chk1("t6_c6_rf_gnt", rf_gnt_o, 1'b1);
    chk1("t6_c6_core_gnt", core_gnt_o, 1'b0);

    // Reset in the middle of the burst
    cyc();
    rst_ni = 1'b0;
    #1;
    chk1("t7_rst_req", data_req_o, 1'b0);
    chk1("t7_rst_core_gnt", core_gnt_o, 1'b0);
    chk1("t7_rst_rf_gnt", rf_gnt_o, 1'b0);
    chk1("t7_rst_busy", busy_o, 1'b0);
    chk1("t7_rst_core_rvalid", core_rvalid_o, 1'b0);
    chk1("t7_rst_rf_rvalid", rf_rvalid_o, 1'b0);
    chk32("t7_rst_addr", data_addr_o, 32'h0);
    cyc();
    clear_inputs();
    rst_ni = 1'b1;
    #1;
    chk1("t7_post_busy", busy_o, 1'b0);
    cyc();
    core_req_i = 1'b1; core_addr_i = 32'hA00; core_be_i = 4'hF; data_gnt_i = 1'b1;
    #1;
    chk1("t7_post_gnt", core_gnt_o, 1'b1);
    cyc();
    clear_inputs(); data_rvalid_i = 1'b1; data_rdata_i = 32'h77;
    #1;
    chk1("t7_post_core_rvalid", core_rvalid_o, 1'b1);
    chk1("t7_post_rf_rvalid", rf_rvalid_o, 1'b0);
    cyc();
    clear_inputs();
    #1;
    chk1("t7_post_idle_busy", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
